// File: rtl/led_pattern_seq.sv
// rtl/led_pattern_seq.sv - programmable looping on/off LED pattern player with brightness PWM
module led_pattern_seq #(
    parameter int UNIT_CYCLES = 1600000,
    parameter int PWM_BITS    = 4
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                EN,
    input  logic                LOAD,
    input  logic [31:0]         PATTERN,
    input  logic [5:0]          LEN,
    input  logic [PWM_BITS-1:0] BRIGHT,
    output logic                LED,
    output logic                BUSY,
    output logic                WRAP
);

    localparam int PW = (UNIT_CYCLES > 2) ? $clog2(UNIT_CYCLES) : 1;

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t              state, state_nxt;
    logic [PW-1:0]       presc;
    logic [4:0]          idx;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [31:0]         act_pat, sh_pat;
    logic [5:0]          act_len, sh_len;
    logic                pending;
    logic                led_q, wrap_q;

    logic [5:0] len_in;
    logic [5:0] next_len;
    logic [5:0] idle_len;
    logic       unit_tick, last_bit, wrap_evt;
    logic       apply_wrap, apply_idle;
    logic       pwm_on;

    assign len_in     = (LEN > 6'd32) ? 6'd32 : LEN;
    assign unit_tick  = (presc == PW'(UNIT_CYCLES - 1));
    assign last_bit   = ({1'b0, idx} == (act_len - 6'd1));
    assign wrap_evt   = (state == S_RUN) && EN && unit_tick && last_bit;
    assign apply_wrap = wrap_evt && pending;
    assign apply_idle = (state == S_IDLE) && !LOAD && pending;
    // Length that becomes active once any pending shadow is applied.
    assign next_len   = pending ? sh_len : act_len;
    assign idle_len   = LOAD ? len_in : next_len;
    assign pwm_on     = (pwm_cnt <= BRIGHT);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (EN && (idle_len != 6'd0)) state_nxt = S_RUN;
            S_RUN: begin
                if (!EN) begin
                    state_nxt = S_IDLE;
                end else if (wrap_evt && (next_len == 6'd0)) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        BUSY = (state == S_RUN);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            presc   <= '0;
            idx     <= '0;
            pwm_cnt <= '0;
            act_pat <= '0;
            act_len <= '0;
            sh_pat  <= '0;
            sh_len  <= '0;
            pending <= 1'b0;
            led_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            led_q   <= (state == S_RUN) && act_pat[idx] && pwm_on;
            wrap_q  <= wrap_evt;

            if ((state == S_IDLE) || !EN) begin
                presc <= '0;
                idx   <= '0;
            end else if (unit_tick) begin
                presc <= '0;
                idx   <= last_bit ? 5'd0 : idx + 5'd1;
            end else begin
                presc <= presc + PW'(1);
            end

            if ((state == S_IDLE) && LOAD) begin
                act_pat <= PATTERN;
                act_len <= len_in;
            end else if (apply_idle || apply_wrap) begin
                act_pat <= sh_pat;
                act_len <= sh_len;
            end

            // A LOAD while running always leaves a fresh shadow pending, even on a wrap cycle.
            if ((state == S_RUN) && LOAD) begin
                sh_pat  <= PATTERN;
                sh_len  <= len_in;
                pending <= 1'b1;
            end else if (apply_idle || apply_wrap || ((state == S_IDLE) && LOAD)) begin
                pending <= 1'b0;
            end
        end
    end

    assign LED  = led_q;
    assign WRAP = wrap_q;

endmodule

// File: doc/led_pattern_seq.md
Name: led_pattern_seq

Overview:
- Downstream LED driver for the TinyFPGA BX 16 MHz designs.
- Replaces the free-running blink counter with a programmable on/off pattern player that plays up to 32 bits, one bit per time unit, and loops.
- Contains its own unit prescaler, a brightness PWM, and a small run/idle FSM.
- Drives the board LED pin directly.

Parameters:
- UNIT_CYCLES, 1600000, CLK cycles per pattern bit (100 ms at 16 MHz); must be >= 2.
- PWM_BITS, 4, width of the brightness PWM counter and of BRIGHT.

Ports:
- CLK  in  1  system clock (16 MHz on board).
- RST_N  in  1  asynchronous active-low reset.
- EN  in  1  level; 1 = play, 0 = stop.
- LOAD  in  1  single-cycle strobe that latches PATTERN and LEN.
- PATTERN  in  32  on/off bits; bit 0 plays first.
- LEN  in  6  number of pattern bits to play (1..32). 0 means "no pattern". Values above 32 are clamped to 32.
- BRIGHT  in  PWM_BITS  on-brightness; duty is (BRIGHT+1)/2^PWM_BITS.
- LED  out  1  registered LED drive.
- BUSY  out  1  high while in RUN.
- WRAP  out  1  one-cycle pulse when the last pattern bit completes.

Behaviour:
- Reset (RST_N=0, async): all registers return to their reset values.
  - LED=0, BUSY=0, WRAP=0.
  - Active and shadow PATTERN/LEN = 0, shadow-pending flag = 0.
  - Prescaler, bit index and PWM counter = 0.
  - State = IDLE.
  - Reset mid-run aborts immediately.
- PWM counter: free-running, PWM_BITS wide, wraps 2^PWM_BITS-1 -> 0. pwm_on = (pwm_cnt <= BRIGHT).
- LOAD, in IDLE: active PATTERN/LEN are written on the LOAD cycle.
- LOAD, in RUN: values go to the shadow registers and set pending. Pending is applied on the next wrap so a pattern is never torn. A second LOAD before the wrap overwrites the shadow.
- State IDLE:
  - Prescaler and index are held at 0. LED=0, BUSY=0.
  - If EN=1 and active LEN!=0, go to RUN on the next edge.
  - If LOAD and EN occur in the same cycle, the newly loaded LEN is used for the decision.
- State RUN:
  - BUSY=1.
  - Prescaler counts 0..UNIT_CYCLES-1. unit_tick is asserted when prescaler==UNIT_CYCLES-1.
  - On unit_tick with index<LEN-1: index += 1.
  - On unit_tick with index==LEN-1:
    - index <- 0 and WRAP=1 for exactly one cycle (the following cycle).
    - If pending, the shadow values are copied to active and pending is cleared.
    - If the new LEN==0, go to IDLE.
  - EN=0 in RUN: go to IDLE on the next edge. Index and prescaler are cleared and no WRAP is generated.
- LED register: LED <= (state==RUN) & PATTERN[index] & pwm_on.
  - LED therefore lags the state/index registers by 1 cycle.
  - First LED=1 for a 1-bit pattern appears 2 cycles after the EN-high edge (subject to pwm_on).
- Unit length:
  - Every bit lasts exactly UNIT_CYCLES cycles, including the first one after RUN entry.
  - One loop of the pattern = LEN*UNIT_CYCLES cycles. WRAP pulses are spaced by exactly that amount.
- Simultaneous events:
  - EN falls on the same cycle as a unit_tick at the last bit: EN wins. Go to IDLE, no WRAP, no shadow apply; pending remains set.
  - A pending shadow is applied when the block next enters IDLE via EN=0, so a restart plays the newest pattern.

Test Plan:
1. Reset checks, UNIT_CYCLES=4, PWM_BITS=4, BRIGHT=15.
   - Assert RST_N=0 mid-run -> LED, BUSY and WRAP go to 0 immediately (asynchronous, not on a clock edge).
   - After release, EN=1 with LEN=0 -> BUSY stays 0.
2. LOAD PATTERN=0b1011, LEN=4, then EN=1:
   - BUSY rises 1 cycle later.
   - LED sequence per 4-cycle unit is 1,1,0,1, repeating.
   - WRAP pulses every 16 cycles, one cycle wide.
3. BRIGHT=3, PATTERN=all-ones, LEN=1 -> LED is high 4 of every 16 cycles; WRAP pulses every 4 cycles.
4. Mid-run LOAD of PATTERN=0x0, LEN=2 while playing LEN=4:
   - The old pattern finishes its current loop.
   - The new pattern starts exactly at the WRAP, and LED stays 0 after that.
5. Mid-run LOAD of LEN=0 -> the block enters IDLE at the next wrap: BUSY=0, LED=0.
6. EN dropped on a last-bit unit_tick -> no WRAP, BUSY falls the next cycle. Re-asserting EN restarts at bit 0 with a full 4-cycle first unit.
